// File: rtl/uart_tx_frame.sv
// uart_tx_frame: standalone UART transmitter.
// One byte per accepted write goes out as: start bit, 8 data bits, optional
// parity bit, then 1 or 2 stop bits. Every line bit lasts DIVISOR clocks.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, tx_ready=1, waiting for tx_wr_ev
// START  | start bit (line low) for one bit time
// DATA   | 8 data bits, shift register LSB on the line
// PARITY | parity bit computed at accept time (parity enabled only)
// STOP   | stop bit(s), line high; the last one returns to IDLE
module uart_tx_frame #(
  parameter int         CLK_FRE            = 50000000,
  parameter int         BAUD_RATE          = 115200,
  parameter int         DIVISOR            = CLK_FRE / BAUD_RATE,
  parameter logic       TRANS_BIT_ORDER    = 1'b0,
  parameter logic [1:0] TRANS_STOP_BIT_NUM = 2'd1,
  parameter logic [1:0] PARITY_MODE        = 2'd0
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] tx_dat,
  input  logic       tx_wr_ev,
  output logic       tx_ready,
  output logic       tx_dat_ser,
  output logic       tx_done_ev,
  output logic       tx_busy
);

  // Last count value of one bit time.
  localparam logic [15:0] BAUD_TC  = 16'(DIVISOR - 1);
  localparam logic        STOP_TWO = (TRANS_STOP_BIT_NUM == 2'd2);
  localparam logic        PAR_EN   = (PARITY_MODE == 2'd1) || (PARITY_MODE == 2'd2);
  localparam logic        PAR_ODD  = (PARITY_MODE == 2'd2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic        stop_idx;

  logic [7:0]  dat_in;
  logic        par_calc;
  logic        baud_tc;

  // Byte as it enters the shifter: reversed for MSB-first so bit 0 always leads.
  always_comb begin
    dat_in = tx_dat;
    if (TRANS_BIT_ORDER) begin
      for (int i = 0; i < 8; i++) begin
        dat_in[i] = tx_dat[7-i];
      end
    end
  end

  // Parity of the byte being accepted; bit order does not affect it.
  always_comb begin
    par_calc = ^tx_dat;
    if (PAR_ODD) begin
      par_calc = ~^tx_dat;
    end
  end

  // End of the current bit time.
  always_comb begin
    baud_tc = (baud_cnt == BAUD_TC);
  end

  // Frame sequencer with registered line and handshake outputs.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
      stop_idx   <= 1'b0;
      tx_dat_ser <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done_ev <= 1'b0;
    end else begin
      tx_done_ev <= 1'b0;
      case (state)
        IDLE: begin
          tx_dat_ser <= 1'b1;
          baud_cnt   <= 16'd0;
          if (tx_wr_ev && tx_ready) begin
            state      <= START;
            shift_reg  <= dat_in;
            parity_bit <= par_calc;
            bit_idx    <= 3'd0;
            stop_idx   <= 1'b0;
            tx_dat_ser <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end

        START: begin
          if (baud_tc) begin
            baud_cnt   <= 16'd0;
            state      <= DATA;
            tx_dat_ser <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DATA: begin
          if (baud_tc) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              if (PAR_EN) begin
                state      <= PARITY;
                tx_dat_ser <= parity_bit;
              end else begin
                state      <= STOP;
                tx_dat_ser <= 1'b1;
              end
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              shift_reg  <= {1'b0, shift_reg[7:1]};
              tx_dat_ser <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        PARITY: begin
          if (baud_tc) begin
            baud_cnt   <= 16'd0;
            state      <= STOP;
            tx_dat_ser <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        STOP: begin
          tx_dat_ser <= 1'b1;
          if (baud_tc) begin
            baud_cnt <= 16'd0;
            if (!STOP_TWO || stop_idx) begin
              state      <= IDLE;
              stop_idx   <= 1'b0;
              tx_ready   <= 1'b1;
              tx_busy    <= 1'b0;
              tx_done_ev <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          state      <= IDLE;
          baud_cnt   <= 16'd0;
          bit_idx    <= 3'd0;
          stop_idx   <= 1'b0;
          tx_dat_ser <= 1'b1;
          tx_ready   <= 1'b1;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame.
// Four instances with DIVISOR=4 cover LSB/1 stop, MSB/2 stop, even and odd parity.
// Expected line bit vectors are hand-computed, bit k = k-th bit on the line.
module tb_uart_tx_frame;

  localparam int DIV = 4;

  logic       sys_clk;
  logic       rst;
  logic [7:0] tx_dat [4];
  logic [3:0] tx_wr_ev;
  logic [3:0] tx_ready;
  logic [3:0] tx_dat_ser;
  logic [3:0] tx_done_ev;
  logic [3:0] tx_busy;

  int n_checks = 0;
  int n_errors = 0;

  // LSB first, 1 stop, no parity
  uart_tx_frame #(.DIVISOR(DIV), .TRANS_BIT_ORDER(1'b0), .TRANS_STOP_BIT_NUM(2'd1),
                  .PARITY_MODE(2'd0)) u_dut_a (
    .sys_clk(sys_clk), .rst(rst), .tx_dat(tx_dat[0]), .tx_wr_ev(tx_wr_ev[0]),
    .tx_ready(tx_ready[0]), .tx_dat_ser(tx_dat_ser[0]), .tx_done_ev(tx_done_ev[0]),
    .tx_busy(tx_busy[0]));

  // MSB first, 2 stop, no parity
  uart_tx_frame #(.DIVISOR(DIV), .TRANS_BIT_ORDER(1'b1), .TRANS_STOP_BIT_NUM(2'd2),
                  .PARITY_MODE(2'd0)) u_dut_b (
    .sys_clk(sys_clk), .rst(rst), .tx_dat(tx_dat[1]), .tx_wr_ev(tx_wr_ev[1]),
    .tx_ready(tx_ready[1]), .tx_dat_ser(tx_dat_ser[1]), .tx_done_ev(tx_done_ev[1]),
    .tx_busy(tx_busy[1]));

  // LSB first, 1 stop, even parity
  uart_tx_frame #(.DIVISOR(DIV), .TRANS_BIT_ORDER(1'b0), .TRANS_STOP_BIT_NUM(2'd1),
                  .PARITY_MODE(2'd1)) u_dut_c (
    .sys_clk(sys_clk), .rst(rst), .tx_dat(tx_dat[2]), .tx_wr_ev(tx_wr_ev[2]),
    .tx_ready(tx_ready[2]), .tx_dat_ser(tx_dat_ser[2]), .tx_done_ev(tx_done_ev[2]),
    .tx_busy(tx_busy[2]));

  // LSB first, 1 stop, odd parity
  uart_tx_frame #(.DIVISOR(DIV), .TRANS_BIT_ORDER(1'b0), .TRANS_STOP_BIT_NUM(2'd1),
                  .PARITY_MODE(2'd2)) u_dut_d (
    .sys_clk(sys_clk), .rst(rst), .tx_dat(tx_dat[3]), .tx_wr_ev(tx_wr_ev[3]),
    .tx_ready(tx_ready[3]), .tx_dat_ser(tx_dat_ser[3]), .tx_done_ev(tx_done_ev[3]),
    .tx_busy(tx_busy[3]));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_val);
    end
  endtask

  // Called at a negedge with the instance idle; returns at the negedge after the accepting edge.
  task automatic start_write(input int idx, input logic [7:0] data);
    tx_dat[idx]   = data;
    tx_wr_ev[idx] = 1'b1;
    @(negedge sys_clk);
    tx_wr_ev[idx] = 1'b0;
    tx_dat[idx]   = ~data;
  endtask

  // Follows one frame cycle by cycle, then checks the done pulse; optionally chains a write.
  task automatic watch_frame(input int idx, input logic [11:0] exp_bits, input int nbits,
                             input int junk_at, input bit chain, input logic [7:0] next_dat,
                             input string tag);
    int line_err = 0;
    int stat_err = 0;
    for (int c = 0; c < nbits * DIV; c++) begin
      if (c > 0) @(negedge sys_clk);
      tx_wr_ev[idx] = 1'b0;
      if (tx_dat_ser[idx] !== exp_bits[c / DIV]) line_err++;
      if (tx_ready[idx] !== 1'b0 || tx_busy[idx] !== 1'b1 || tx_done_ev[idx] !== 1'b0) stat_err++;
      if (c == junk_at) begin
        tx_dat[idx]   = 8'hFF;
        tx_wr_ev[idx] = 1'b1;
      end
    end
    check_val({tag, "_line_errs"}, line_err, 0);
    check_val({tag, "_busy_errs"}, stat_err, 0);
    @(negedge sys_clk);
    check_val({tag, "_done"}, {31'd0, tx_done_ev[idx]}, 1);
    check_val({tag, "_ready"}, {31'd0, tx_ready[idx]}, 1);
    check_val({tag, "_idle_line"}, {31'd0, tx_dat_ser[idx]}, 1);
    if (chain) begin
      tx_dat[idx]   = next_dat;
      tx_wr_ev[idx] = 1'b1;
      @(negedge sys_clk);
      tx_wr_ev[idx] = 1'b0;
      tx_dat[idx]   = ~next_dat;
      check_val({tag, "_done_once"}, {31'd0, tx_done_ev[idx]}, 0);
      check_val({tag, "_b2b_start"}, {31'd0, tx_dat_ser[idx]}, 0);
    end else begin
      @(negedge sys_clk);
      check_val({tag, "_done_once"}, {31'd0, tx_done_ev[idx]}, 0);
    end
  endtask

  initial begin
    int bad;
    rst      = 1'b0;
    tx_wr_ev = 4'd0;
    for (int i = 0; i < 4; i++) tx_dat[i] = 8'h00;

    #50;
    check_val("rst_line", {28'd0, tx_dat_ser}, 4'hF);
    check_val("rst_ready", {28'd0, tx_ready}, 4'hF);
    check_val("rst_busy", {28'd0, tx_busy}, 4'h0);
    check_val("rst_done", {28'd0, tx_done_ev}, 4'h0);
    #50;
    @(negedge sys_clk);
    rst = 1'b1;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (tx_dat_ser !== 4'hF || tx_ready !== 4'hF || tx_done_ev !== 4'h0 || tx_busy !== 4'h0) bad++;
    end
    check_val("idle_1000", bad, 0);

    // 8'h55 LSB first: 0,1,0,1,0,1,0,1,0,1
    start_write(0, 8'h55);
    watch_frame(0, 12'h2AA, 10, -1, 1'b0, 8'h00, "a_55");

    // 8'hA1 MSB first, 2 stop: 0,1,0,1,0,0,0,0,1,1,1
    start_write(1, 8'hA1);
    watch_frame(1, 12'h70A, 11, -1, 1'b0, 8'h00, "b_a1");

    // 8'h07 even parity -> parity 1
    start_write(2, 8'h07);
    watch_frame(2, 12'h60E, 11, -1, 1'b0, 8'h00, "c_07_even");

    // 8'h07 odd parity -> parity 0
    start_write(3, 8'h07);
    watch_frame(3, 12'h40E, 11, -1, 1'b0, 8'h00, "d_07_odd");

    // 8'h3C with an ignored 8'hFF write mid-frame, then 8'hC3 in the done cycle
    start_write(0, 8'h3C);
    watch_frame(0, 12'h278, 10, 13, 1'b1, 8'hC3, "a_3c");
    watch_frame(0, 12'h386, 10, -1, 1'b0, 8'h00, "a_c3");

    // Reset during data bit 4 (line bits 20..23 cycles for 8'h00)
    start_write(0, 8'h00);
    repeat (21) @(negedge sys_clk);
    check_val("pre_rst_low", {31'd0, tx_dat_ser[0]}, 0);
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_line", {31'd0, tx_dat_ser[0]}, 1);
    check_val("mid_rst_ready", {31'd0, tx_ready[0]}, 1);
    check_val("mid_rst_busy", {31'd0, tx_busy[0]}, 0);
    @(negedge sys_clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (tx_dat_ser[0] !== 1'b1 || tx_done_ev[0] !== 1'b0 || tx_ready[0] !== 1'b1) bad++;
    end
    check_val("post_rst_quiet", bad, 0);

    // Normal frame after the abandoned one: 8'hA5 LSB first
    start_write(0, 8'hA5);
    watch_frame(0, 12'h34A, 10, -1, 1'b0, 8'h00, "a_a5");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
